prog_mem_loader: RTL and testbench

//  Boot-time loader sitting upstream of the PIC16C55 core's program memory.
//  - Accepts a framed byte stream (from a UART receiver) and writes 12-bit instruction words into a RAM-based program memory.
//  - Holds the core in reset until a complete frame with a valid checksum has loaded.
//  - After the load, hands the memory address bus to the core PC.

---
 rtl/prog_mem_loader.sv | 127 ++++++++++++
 tb/tb_prog_mem_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// Boot loader: receives a framed byte stream, writes 12-bit words into program memory,
// and releases the core from reset once the frame checksum verifies.
module prog_mem_loader #(
    parameter int         PC_WIDTH   = 9,
    parameter int         INST_WIDTH = 12,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    output logic                  rxReady,
    input  logic [PC_WIDTH-1:0]   pcIn,
    output logic [PC_WIDTH-1:0]   memAddr,
    output logic [INST_WIDTH-1:0] memWData,
    output logic                  memWe,
    output logic                  coreRst_n,
    output logic                  loadDone,
    output logic                  loadErr,
    output logic [PC_WIDTH:0]     wordCount
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0]     MAX_COUNT = 17'(2 ** PC_WIDTH);
    localparam logic [PC_WIDTH:0] ONE     = (PC_WIDTH + 1)'(1);

    state_t                state, state_nx;
    logic [7:0]            cnt_hi;
    logic [PC_WIDTH:0]     word_total;
    logic [7:0]            lo_byte;
    logic [7:0]            sum;
    logic [PC_WIDTH-1:0]   wr_addr;
    logic                  accept;
    logic [15:0]           count_full;
    logic                  count_bad;
    logic                  last_word;
    logic                  is_sync;

    assign accept     = rxValid && rxReady;
    assign is_sync    = (rxData == SYNC_BYTE);
    assign count_full = {cnt_hi, rxData};
    assign count_bad  = (count_full == 16'd0) || ({1'b0, count_full} > MAX_COUNT);
    assign last_word  = ((wordCount + ONE) == word_total);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            case (state)
                S_IDLE, S_ERROR: if (is_sync) state_nx = S_CNT_HI;
                S_CNT_HI:        state_nx = S_CNT_LO;
                S_CNT_LO:        state_nx = count_bad ? S_ERROR : S_DATA_LO;
                S_DATA_LO:       state_nx = S_DATA_HI;
                S_DATA_HI:       state_nx = last_word ? S_CHECK : S_DATA_LO;
                S_CHECK:         state_nx = (rxData == sum) ? S_DONE : S_ERROR;
                default:         state_nx = state;
            endcase
        end
    end

    // rxReady is gated by rst directly so it is low throughout reset and high on release.
    always_comb begin
        rxReady   = !rst && (state != S_DONE);
        loadDone  = (state == S_DONE);
        coreRst_n = (state == S_DONE);
        loadErr   = (state == S_ERROR);
        memAddr   = (state == S_DONE) ? pcIn : wr_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_hi     <= '0;
            word_total <= '0;
            lo_byte    <= '0;
            sum        <= '0;
            wordCount  <= '0;
            wr_addr    <= '0;
            memWe      <= 1'b0;
            memWData   <= '0;
        end else begin
            memWe <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (is_sync) begin
                            sum       <= '0;
                            wordCount <= '0;
                            wr_addr   <= '0;
                        end
                    end
                    S_CNT_HI: begin
                        cnt_hi <= rxData;
                        sum    <= sum + rxData;
                    end
                    S_CNT_LO: begin
                        word_total <= count_full[PC_WIDTH:0];
                        sum        <= sum + rxData;
                    end
                    S_DATA_LO: begin
                        lo_byte <= rxData;
                        sum     <= sum + rxData;
                    end
                    S_DATA_HI: begin
                        // wr_addr keeps the index of the word being written while wordCount moves on
                        memWe     <= 1'b1;
                        memWData  <= {rxData[INST_WIDTH-9:0], lo_byte};
                        wr_addr   <= wordCount[PC_WIDTH-1:0];
                        wordCount <= wordCount + ONE;
                        sum       <= sum + rxData;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized self-checking bench for prog_mem_loader; expected writes and outcome
// are derived from the frame bytes by a simple reference model.
module tb_prog_mem_loader;

    localparam int PCW = 9;
    localparam int IW  = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     rxData;
    logic           rxValid;
    logic           rxReady;
    logic [PCW-1:0] pcIn;
    logic [PCW-1:0] memAddr;
    logic [IW-1:0]  memWData;
    logic           memWe;
    logic           coreRst_n;
    logic           loadDone;
    logic           loadErr;
    logic [PCW:0]   wordCount;

    int total = 0;
    int bad   = 0;

    logic [7:0] frame_q[$];
    int         exp_data[$];
    int         obs_addr[$];
    int         obs_data[$];
    int         obs_wc[$];

    prog_mem_loader #(.PC_WIDTH(PCW), .INST_WIDTH(IW), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .rxReady   (rxReady),
        .pcIn      (pcIn),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memWe     (memWe),
        .coreRst_n (coreRst_n),
        .loadDone  (loadDone),
        .loadErr   (loadErr),
        .wordCount (wordCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            obs_addr.push_back(int'(memAddr));
            obs_data.push_back(int'(memWData));
            obs_wc.push_back(int'(wordCount));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rxValid = 1'b0;
        rst     = 1'b1;
        #1;
        check_val("rst_ready", rxReady, 0);
        check_val("rst_we", memWe, 0);
        check_val("rst_wdata", memWData, 0);
        check_val("rst_core", coreRst_n, 0);
        check_val("rst_done", loadDone, 0);
        check_val("rst_err", loadErr, 0);
        check_val("rst_wc", wordCount, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("ready_after_rst", rxReady, 1);
    endtask

    // Called at negedge+1; returns at negedge+1 after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        int gap;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        rxValid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            #1;
        end
        pcIn    = PCW'($urandom);
        rxData  = b;
        rxValid = 1'b1;
        n = 0;
        while (!rxReady && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rxReady) check_val("ready_timeout", rxReady, 1);
        @(negedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic build_frame(input int cnt, input bit corrupt);
        logic [7:0] lo;
        logic [7:0] hi;
        int         s;
        int         nw;
        frame_q.delete();
        exp_data.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(cnt >> 8));
        frame_q.push_back(8'(cnt));
        s  = (cnt >> 8) + (cnt & 255);
        nw = (cnt >= 1 && cnt <= 512) ? cnt : 0;
        for (int i = 0; i < nw; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            frame_q.push_back(lo);
            frame_q.push_back(hi);
            exp_data.push_back(((hi & 15) << 8) | lo);
            s += lo + hi;
        end
        if (nw > 0) begin
            if (corrupt) s += $urandom_range(1, 255);
            frame_q.push_back(8'(s % 256));
        end
    endtask

    task automatic load_frame1(input logic [7:0] chk);
        logic [7:0] f1 [10] = '{8'hA5, 8'h00, 8'h03, 8'h05, 8'h0C, 8'h12, 8'h0A, 8'hFF, 8'h0F, 8'h3E};
        frame_q.delete();
        exp_data.delete();
        for (int i = 0; i < 9; i++) frame_q.push_back(f1[i]);
        frame_q.push_back(chk);
        exp_data.push_back('hC05);
        exp_data.push_back('hA12);
        exp_data.push_back('hFFF);
    endtask

    task automatic run_frame(input int max_gap, input bit junk);
        int  base;
        int  cnt;
        int  s;
        bit  count_ok;
        bit  exp_ok;
        int  nw;
        if (junk) begin
            send_byte(8'h00, max_gap);
            send_byte(8'hFF, max_gap);
            send_byte(8'(($urandom_range(0, 254) + 8'hA6) % 256), max_gap);
        end
        base = obs_addr.size();
        for (int i = 0; i < frame_q.size() - 1; i++) send_byte(frame_q[i], max_gap);
        check_val("done_early", loadDone, 0);
        send_byte(frame_q[frame_q.size() - 1], max_gap);

        cnt      = (int'(frame_q[1]) << 8) | int'(frame_q[2]);
        count_ok = (cnt >= 1) && (cnt <= 512);
        nw       = count_ok ? cnt : 0;
        exp_ok   = 1'b0;
        if (count_ok) begin
            s = 0;
            for (int i = 1; i < frame_q.size() - 1; i++) s += frame_q[i];
            exp_ok = ((s % 256) == int'(frame_q[frame_q.size() - 1]));
        end

        check_val("n_writes", obs_addr.size() - base, nw);
        for (int i = 0; i < nw && base + i < obs_addr.size(); i++) begin
            check_val("wr_addr", obs_addr[base + i], i);
            check_val("wr_data", obs_data[base + i], exp_data[i]);
            check_val("wr_wc", obs_wc[base + i], i + 1);
        end
        check_val("load_done", loadDone, exp_ok);
        check_val("core_rst_n", coreRst_n, exp_ok);
        check_val("load_err", loadErr, !exp_ok);
        check_val("word_count", wordCount, nw);
        check_val("ready_end", rxReady, !exp_ok);
    endtask

    initial begin
        int         base;
        int         cnt;
        logic [PCW-1:0] pv;
        rst     = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        pcIn    = '0;
        do_reset();

        // frame 1 back-to-back
        load_frame1(8'h3E);
        run_frame(0, 0);

        // after DONE: memAddr follows pcIn, input ignored
        for (int i = 0; i < 4; i++) begin
            pv   = (i == 0) ? PCW'('h1FF) : PCW'($urandom);
            pcIn = pv;
            #1;
            check_val("pc_mux", memAddr, pv);
        end
        check_val("done_ready", rxReady, 0);
        base = obs_addr.size();
        rxValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rxData = (i % 2 == 0) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
            #1;
        end
        rxValid = 1'b0;
        check_val("done_no_writes", obs_addr.size() - base, 0);
        check_val("done_hold", loadDone, 1);
        check_val("done_wc", wordCount, 3);

        // bad checksum, then the good frame recovers from ERROR
        do_reset();
        load_frame1(8'h3F);
        run_frame(0, 0);
        load_frame1(8'h3E);
        run_frame(0, 0);

        // count boundaries
        do_reset();
        build_frame(0, 0);
        run_frame(0, 0);
        build_frame(513, 0);
        run_frame(0, 0);
        build_frame(512, 0);
        run_frame(0, 0);

        // frame 1 with gaps and leading junk
        do_reset();
        load_frame1(8'h3E);
        run_frame(5, 1);

        // reset after the second data word, then a normal load
        do_reset();
        build_frame(5, 0);
        base = obs_addr.size();
        for (int i = 0; i < 7; i++) send_byte(frame_q[i], 2);
        check_val("part_writes", obs_addr.size() - base, 2);
        do_reset();
        check_val("part_done", loadDone, 0);
        check_val("part_core", coreRst_n, 0);
        build_frame(5, 0);
        run_frame(2, 0);

        // randomized frames
        for (int k = 0; k < 12; k++) begin
            if (loadDone) do_reset();
            case ($urandom_range(0, 5))
                0:       cnt = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(513, 65535);
                1:       cnt = $urandom_range(1, 2);
                default: cnt = $urandom_range(1, 24);
            endcase
            build_frame(cnt, $urandom_range(0, 2) == 0);
            run_frame(3, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
